// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: ARM front end, req/ack instruction fetch into a prefetch FIFO with field decode and PCSrc redirect
// Ports:
//   Clk, Reset (async, active-low)
//   IMemReq/IMemAddr/IMemAck/IMemRData  instruction memory handshake, one request in flight at most
//   InstrValid/DecReady                 head-of-FIFO handoff to the decoder
//   Instr, Cond, Op, Funct, Rd          head word and its field slices
//   PC, PCPlus8                         head address and its R15 read value
//   PCSrc, BranchTarget                 redirect, honoured only when the head is consumed
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [31:0]       IMemRData,
  output logic              InstrValid,
  input  logic              DecReady,
  output logic [31:0]       Instr,
  output logic [3:0]        Cond,
  output logic [1:0]        Op,
  output logic [5:0]        Funct,
  output logic [3:0]        Rd,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus8,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] BranchTarget
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, tgt_pc, tgt_pc_nxt, target;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic ack, pop, redirect, push, unused_bits;
  assign unused_bits = ^BranchTarget[1:0];
  assign target = {BranchTarget[ADDR_W-1:2], 2'b00};
  // count[PW] set means full since DEPTH is a power of two
  assign IMemReq = (state == DRAIN) | ((state == FETCH) & ~count[PW]);
  assign IMemAddr = fetch_pc;
  assign ack = IMemReq & IMemAck;
  assign InstrValid = count != '0;
  assign pop = InstrValid & DecReady;
  assign redirect = pop & PCSrc;
  assign push = ack & (state == FETCH) & ~redirect;
  assign Instr = data_q[rd_ptr];
  assign PC = addr_q[rd_ptr];
  assign PCPlus8 = PC + ADDR_W'(8);
  assign Cond = Instr[31:28];
  assign Op = Instr[27:26];
  assign Funct = Instr[25:20];
  assign Rd = Instr[15:12];
  always_comb begin
    state_nxt = state;
    fetch_pc_nxt = fetch_pc;
    tgt_pc_nxt = tgt_pc;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        // a request already on the bus cannot be withdrawn, so park the target until it completes
        if (redirect && IMemReq && !IMemAck) begin
          state_nxt = DRAIN;
          tgt_pc_nxt = target;
        end else begin
          fetch_pc_nxt = redirect ? target : ack ? fetch_pc + ADDR_W'(4) : fetch_pc;
        end
      end
      DRAIN: begin
        state_nxt = IMemAck ? FETCH : DRAIN;
        fetch_pc_nxt = IMemAck ? tgt_pc : fetch_pc;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      tgt_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      tgt_pc <= tgt_pc_nxt;
      if (push) begin
        addr_q[wr_ptr] <= fetch_pc;
        data_q[wr_ptr] <= IMemRData;
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the ARM core. Fetches 32-bit instruction words from instruction memory through a req/ack handshake and buffers them in a small prefetch FIFO.
- Presents the head instruction, already split into the Cond/Op/Funct/Rd fields, to the control unit.
- Takes the control unit's PCSrc, together with a branch target, to redirect the fetch PC and flush stale prefetched words.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 0, fetch address after reset; must be word-aligned.
- DEPTH, 2, prefetch FIFO entries (power of two, >=2).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  ADDR_W  fetch address; word-aligned.
- IMemAck  in  1  memory accepts request and returns data this cycle.
- IMemRData  in  32  instruction word; valid when IMemAck=1.
- InstrValid  out  1  head instruction available to the decoder.
- DecReady  in  1  decoder consumes head this cycle.
- Instr  out  32  head instruction word.
- Cond  out  4  Instr[31:28].
- Op  out  2  Instr[27:26].
- Funct  out  6  Instr[25:20].
- Rd  out  4  Instr[15:12].
- PC  out  ADDR_W  address of head instruction.
- PCPlus8  out  ADDR_W  PC+8, the architectural R15 read value.
- PCSrc  in  1  redirect request from the control unit; qualified by consume.
- BranchTarget  in  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset=0, asynchronously:
  - fetch PC=RESET_PC; FIFO empty; no outstanding request.
  - IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instr=0; PC and PCPlus8 reflect entry 0 (don't care while InstrValid=0).
  - State goes to IDLE.
- States:
  - IDLE: first cycle after reset release; go to FETCH with no request issued.
  - FETCH: IMemReq=1 when count+outstanding<DEPTH.
  - DRAIN: an in-flight request must be discarded.
- Handshake:
  - At most one outstanding request.
  - Once IMemReq=1, IMemReq and IMemAddr are held stable until the IMemAck cycle; the request is never withdrawn.
  - Ack may arrive in the same cycle as the request or any later cycle.
  - IMemAck while IMemReq=0 is ignored.
- Ack in FETCH with no redirect:
  - push {IMemAddr, IMemRData}; fetch PC += 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0).
  - A new request may be asserted in the next cycle, not the same cycle.
- Output: InstrValid = FIFO non-empty. Fields are pure slices of the head word. The head is popped when InstrValid & DecReady.
- Full FIFO: IMemReq stays 0 until a pop frees a slot. A pop and a push in the same cycle keep count unchanged.
- Redirect: triggers only when PCSrc & InstrValid & DecReady. PCSrc under any other condition is ignored. On redirect:
  - FIFO flushed, including any word acked that same cycle.
  - fetch PC := {BranchTarget[ADDR_W-1:2], 2'b00}.
  - If a request is in flight and not acked this cycle, go to DRAIN.
  - Otherwise stay in FETCH; the request to the target is issued next cycle.
- DRAIN: IMemReq and old IMemAddr are held. On ack, data is discarded and the state returns to FETCH. InstrValid=0 throughout DRAIN.
- Reset asserted mid-request or mid-drain: immediate return to reset values. The pending ack is ignored.
- Latency: a request acked in cycle N gives InstrValid=1 in cycle N+1 if the FIFO was empty. Redirect in cycle N gives the first target request in cycle N+1 (no drain).

Test Plan:
- Reset release, memory acks same cycle with words 0xE3A01005, 0xE2811001 → IMemAddr 0x0 then 0x4. First InstrValid 2 cycles after reset release. Cond=0xE, Op=0, Funct=0x3A, Rd=1, PC=0, PCPlus8=8.
- DecReady=0 with immediate acks → exactly DEPTH=2 words buffered, then IMemReq=0. DecReady=1 for one cycle → one pop, then one new request to 0x8.
- Memory with 3-cycle ack latency → IMemReq and IMemAddr stable for all 3 cycles. No second request issued before the ack.
- PCSrc=1 with BranchTarget=0x103 on a consumed head while a request to 0x8 is in flight → DRAIN. The ack data is dropped, then a request to 0x100. The next InstrValid shows PC=0x100.
- PCSrc=1 with DecReady=0, then PCSrc=1 with InstrValid=0 → no redirect, fetch sequence unchanged.
- RESET_PC=0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Reset=0 during an outstanding request → IMemReq=0 and InstrValid=0 immediately; a refetch from RESET_PC follows release.
